mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter that shares the single-port data memory between two requesters. One requester is the pipeline MEM stage; the other is the loader/debug port, which preloads and inspects data memory. The block sits between the MEM stage and `memorydata` and owns the memory's `Rm`/`Wm`/address/write-data inputs. It issues at most one access per cycle, stalls the MEM stage when it loses, bounds loader starvation, and caps loader burst length.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive pipeline wins with loader waiting before loader is forced a grant (≥1)
- BURST_MAX, 8, maximum consecutive loader grants per burst (≥1)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  reset, synchronous, active-low
- p_req  in  1  MEM-stage access request (Rm or Wm active in MEM)
- p_we  in  1  MEM-stage write (1) / read (0)
- p_addr  in  8  MEM-stage address
- p_wdata  in  8  MEM-stage write data
- p_stall  out  1  MEM stage must hold; combinational, p_req & ~pipeline grant
- p_rvalid  out  1  p_rdata valid (registered)
- p_rdata  out  8  read data to MEM stage (mem_rdata passthrough)
- l_req  in  1  loader access request
- l_we  in  1  loader write/read
- l_addr  in  8  loader address
- l_wdata  in  8  loader write data
- l_gnt  out  1  loader access issued this cycle (combinational)
- l_rvalid  out  1  l_rdata valid (registered)
- l_rdata  out  8  read data to loader (mem_rdata passthrough)
- mem_rm  out  1  memory read enable
- mem_wm  out  1  memory write enable
- mem_addr  out  8  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid the cycle after mem_rm
- burst_active  out  1  state == LOAD

## Operation
- State register: PIPE (default) or LOAD. Counters: starve_cnt (0..STARVE_LIMIT, saturating), burst_cnt (0..BURST_MAX).
- Grant decision is combinational from state, counters, and requests:
  - PIPE:
    - p_req & (~l_req | starve_cnt < STARVE_LIMIT) → pipeline granted.
    - Otherwise l_req → loader granted.
  - LOAD:
    - l_req & burst_cnt < BURST_MAX → loader granted.
    - Otherwise arbitrate exactly as PIPE with starve_cnt taken as 0.
- Memory drive:
  - The granted requester's we selects mem_wm=1 (write) or mem_rm=1 (read).
  - Its addr/wdata go to mem_addr/mem_wdata.
  - No grant → mem_rm=mem_wm=0, mem_addr=mem_wdata=0.
- Next state:
  - Loader granted → LOAD.
  - Otherwise → PIPE.
- starve_cnt:
  - Cleared on loader grant.
  - +1 (saturating) on pipeline grant while l_req=1.
  - Cleared when l_req=0.
- burst_cnt:
  - Set to 1 on loader grant from PIPE (or from LOAD after limit/drop).
  - +1 on loader grant continuing in LOAD.
  - Cleared otherwise.
- rvalid: p_rvalid/l_rvalid ← 1 the cycle after a granted read by that requester, else 0. Writes never raise rvalid.
- Simultaneous p_req/l_req with counters below limits → pipeline wins.
- Requester inputs must be held stable while stalled / not granted.

## Timing
- Reset (reset=0 at an edge):
  - state=PIPE, starve_cnt=0, burst_cnt=0, p_rvalid=l_rvalid=0.
  - While reset=0, all grants are forced 0, so mem_rm=mem_wm=0, p_stall=p_req, l_gnt=0.
- Latency:
  - Grant and memory enable occur in the same cycle as the request (0 cycles).
  - Read data and rvalid arrive one cycle later.
  - Write completes at the grant edge.
- Reset mid-burst: the next cycle is PIPE with counters 0; no access is issued during reset; a pending rvalid is dropped.
- Throughput: one access per cycle, no idle cycle between owners.
- Loader grant latency is bounded: at most STARVE_LIMIT cycles of continuous pipeline traffic.

## Test plan
- Reset: hold reset=0 with p_req=l_req=1 for 3 cycles → mem_rm=mem_wm=0, l_gnt=0, p_stall=1, rvalids 0; release → pipeline granted in the first cycle.
- Pipeline read: p_req=1, p_we=0, p_addr=0x2A; memory holds 0x5C → mem_rm=1, mem_addr=0x2A, p_stall=0 in cycle 0; p_rvalid=1, p_rdata=0x5C in cycle 1.
- Starvation: p_req and l_req held high from cycle 0 (defaults) → pipeline granted cycles 0–3; loader granted cycle 4 with p_stall=1; state LOAD from cycle 5.
- Burst cap: loader granted at cycle 4 with l_req held, p_req held (defaults) → loader granted cycles 4–11 (8 grants); pipeline granted cycles 12–15; loader cycle 16.
- Loader write then pipeline read: l_req=1, l_we=1, l_addr=0x10, l_wdata=0xA5, p_req=0; next cycle l_req=0, p_req=1, p_addr=0x10 → mem_wm=1 in cycle 0; mem_rm=1 in cycle 1, p_stall=0; p_rdata=0xA5, p_rvalid=1 in cycle 2; state PIPE from cycle 2.
- Burst abort: in LOAD with burst_cnt=3, drop l_req while p_req=1 → pipeline granted the same cycle; state PIPE next; burst_cnt=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus between the data-memory arbiter, its two requesters and the single-port data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
    logic       p_req;
    logic       p_we;
    logic [7:0] p_addr;
    logic [7:0] p_wdata;
    logic       p_stall;
    logic       p_rvalid;
    logic [7:0] p_rdata;

    logic       l_req;
    logic       l_we;
    logic [7:0] l_addr;
    logic [7:0] l_wdata;
    logic       l_gnt;
    logic       l_rvalid;
    logic [7:0] l_rdata;

    logic       mem_rm;
    logic       mem_wm;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic       burst_active;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_stall, p_rvalid, p_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_rm, mem_wm, mem_addr, mem_wdata,
        input  mem_rdata,
        output burst_active
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_stall, p_rvalid, p_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_rm, mem_wm, mem_addr, mem_wdata,
        output mem_rdata,
        input  burst_active
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between the MEM stage and the loader/debug port.
// Pipeline has priority, bounded by a starvation limit; loader bursts are length-capped.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM_C = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_MAX_C  = BW'(BURST_MAX);

    typedef enum logic [0:0] {
        ST_PIPE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t        state_r;
    logic [SW-1:0] starve_cnt_r;
    logic [BW-1:0] burst_cnt_r;
    logic          p_rvalid_r;
    logic          l_rvalid_r;

    logic          p_req_s;
    logic          p_we_s;
    logic          l_req_s;
    logic          l_we_s;
    logic          p_gnt_s;
    logic          l_gnt_s;
    logic          burst_cont_s;
    logic          starve_ok_s;
    logic          mem_rm_s;
    logic          mem_wm_s;
    logic [7:0]    mem_addr_s;
    logic [7:0]    mem_wdata_s;

    assign p_req_s = bus.p_req;
    assign p_we_s  = bus.p_we;
    assign l_req_s = bus.l_req;
    assign l_we_s  = bus.l_we;

    // In LOAD the fallback arbitration treats the starvation count as zero.
    assign starve_ok_s = (state_r == ST_LOAD) || (starve_cnt_r < STARVE_LIM_C);

    // Grant decision; everything is forced idle while reset is held low.
    always_comb begin
        p_gnt_s      = 1'b0;
        l_gnt_s      = 1'b0;
        burst_cont_s = 1'b0;
        if (!reset) begin
            p_gnt_s = 1'b0;
        end else if ((state_r == ST_LOAD) && l_req_s && (burst_cnt_r < BURST_MAX_C)) begin
            l_gnt_s      = 1'b1;
            burst_cont_s = 1'b1;
        end else if (p_req_s && (!l_req_s || starve_ok_s)) begin
            p_gnt_s = 1'b1;
        end else if (l_req_s) begin
            l_gnt_s = 1'b1;
        end else begin
            p_gnt_s = 1'b0;
        end
    end

    // Route the winning requester onto the memory port.
    always_comb begin
        mem_rm_s    = 1'b0;
        mem_wm_s    = 1'b0;
        mem_addr_s  = 8'h00;
        mem_wdata_s = 8'h00;
        if (p_gnt_s) begin
            mem_rm_s    = ~p_we_s;
            mem_wm_s    = p_we_s;
            mem_addr_s  = bus.p_addr;
            mem_wdata_s = bus.p_wdata;
        end else if (l_gnt_s) begin
            mem_rm_s    = ~l_we_s;
            mem_wm_s    = l_we_s;
            mem_addr_s  = bus.l_addr;
            mem_wdata_s = bus.l_wdata;
        end else begin
            mem_rm_s = 1'b0;
        end
    end

    // Owner state, starvation/burst counters and read-valid flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_PIPE;
            starve_cnt_r <= {SW{1'b0}};
            burst_cnt_r  <= {BW{1'b0}};
            p_rvalid_r   <= 1'b0;
            l_rvalid_r   <= 1'b0;
        end else begin
            state_r <= l_gnt_s ? ST_LOAD : ST_PIPE;

            if (l_gnt_s || !l_req_s) begin
                starve_cnt_r <= {SW{1'b0}};
            end else if (p_gnt_s && (starve_cnt_r < STARVE_LIM_C)) begin
                starve_cnt_r <= starve_cnt_r + SW'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end

            if (l_gnt_s && burst_cont_s) begin
                burst_cnt_r <= burst_cnt_r + BW'(1);
            end else if (l_gnt_s) begin
                burst_cnt_r <= BW'(1);
            end else begin
                burst_cnt_r <= {BW{1'b0}};
            end

            p_rvalid_r <= p_gnt_s & ~p_we_s;
            l_rvalid_r <= l_gnt_s & ~l_we_s;
        end
    end

    assign bus.p_stall      = p_req_s & ~p_gnt_s;
    assign bus.l_gnt        = l_gnt_s;
    assign bus.p_rvalid     = p_rvalid_r;
    assign bus.l_rvalid     = l_rvalid_r;
    assign bus.p_rdata      = bus.mem_rdata;
    assign bus.l_rdata      = bus.mem_rdata;
    assign bus.mem_rm       = mem_rm_s;
    assign bus.mem_wm       = mem_wm_s;
    assign bus.mem_addr     = mem_addr_s;
    assign bus.mem_wdata    = mem_wdata_s;
    assign bus.burst_active = (state_r == ST_LOAD);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// all compared against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;
    localparam int SL = 4;
    localparam int BM = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural single-port memory with one-cycle read latency.
    logic [7:0] mem [256];
    logic [7:0] rdata_q;
    logic       mem_init;
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        end else begin
            if (bus.mem_wm) mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_rm) rdata_q <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdata_q;

    int errors = 0;
    int checks = 0;

    // Reference model: streak of pipeline wins while loader waits, length of current loader run.
    logic [7:0] shadow [256];
    int         m_streak;
    int         m_run;
    bit         m_prv, m_lrv;
    logic [7:0] m_prd, m_lrd;
    bit         last_pg, last_lg;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational/registered outputs, advance the model.
    task automatic step(input bit rst, input bit pr, input bit pw, input logic [7:0] pa, input logic [7:0] pd,
                        input bit lr, input bit lw, input logic [7:0] la, input logic [7:0] ld);
        bit pg, lg, erm, ewm;
        logic [7:0] ea, ed;
        @(negedge clock);
        reset = rst;
        bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pd;
        bus.l_req = lr; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = ld;
        #1;
        pg = 1'b0; lg = 1'b0;
        if (rst) begin
            if (lr && m_run > 0 && m_run < BM) lg = 1'b1;
            else if (pr && (!lr || m_run > 0 || m_streak < SL)) pg = 1'b1;
            else if (lr) lg = 1'b1;
        end
        erm = (pg && !pw) || (lg && !lw);
        ewm = (pg && pw) || (lg && lw);
        ea  = pg ? pa : (lg ? la : 8'h00);
        ed  = pg ? pd : (lg ? ld : 8'h00);
        check_val("p_stall",   32'(bus.p_stall),  32'(pr && !pg));
        check_val("l_gnt",     32'(bus.l_gnt),    32'(lg));
        check_val("mem_rm",    32'(bus.mem_rm),   32'(erm));
        check_val("mem_wm",    32'(bus.mem_wm),   32'(ewm));
        check_val("mem_addr",  32'(bus.mem_addr), 32'(ea));
        check_val("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
        check_val("burst_active", 32'(bus.burst_active), 32'(m_run > 0));
        check_val("p_rvalid",  32'(bus.p_rvalid), 32'(m_prv));
        check_val("l_rvalid",  32'(bus.l_rvalid), 32'(m_lrv));
        if (m_prv) check_val("p_rdata", 32'(bus.p_rdata), 32'(m_prd));
        if (m_lrv) check_val("l_rdata", 32'(bus.l_rdata), 32'(m_lrd));

        m_prv = pg && !pw;
        m_lrv = lg && !lw;
        m_prd = shadow[pa];
        m_lrd = shadow[la];
        if (pg && pw) shadow[pa] = pd;
        if (lg && lw) shadow[la] = ld;
        if (!rst || !lr || lg) m_streak = 0;
        else if (pg) m_streak = (m_streak + 1 > SL) ? SL : m_streak + 1;
        if (!rst)    m_run = 0;
        else if (lg) m_run = (m_run > 0 && m_run < BM) ? m_run + 1 : 1;
        else         m_run = 0;
        last_pg = pg;
        last_lg = lg;
    endtask

    bit         c_pr, c_pw, c_lr, c_lw, c_rst;
    logic [7:0] c_pa, c_pd, c_la, c_ld;
    logic [31:0] gmask;

    initial begin
        reset = 1'b0;
        bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = 8'h00; bus.p_wdata = 8'h00;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 8'h00; bus.l_wdata = 8'h00;
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 7 + 3);
        m_streak = 0; m_run = 0; m_prv = 1'b0; m_lrv = 1'b0;
        m_prd = 8'h00; m_lrd = 8'h00; last_pg = 1'b0; last_lg = 1'b0;
        mem_init = 1'b1;
        repeat (2) @(posedge clock);
        #1 mem_init = 1'b0;

        // Reset held with both requesting: no access, pipeline stalled.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00);
            check_val("rst_stall", 32'(bus.p_stall), 32'd1);
            check_val("rst_lgnt",  32'(bus.l_gnt),   32'd0);
        end

        // Release with both held: starvation then burst cap pattern over 17 cycles.
        gmask = 32'h0;
        for (int c = 0; c < 17; c++) begin
            step(1'b1, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00);
            if (c == 0) check_val("release_pgrant", 32'(bus.p_stall), 32'd0);
            gmask[c] = bus.l_gnt;
        end
        check_val("starve_burst_pattern", gmask, 32'h0001_0FF0);

        // Reset in the middle of a loader burst.
        step(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check_val("rst_midburst_state", 32'(bus.burst_active), 32'd0);
        check_val("rst_midburst_rvalid", 32'(bus.l_rvalid), 32'd0);

        // Loader write 0x5C to 0x2A, then pipeline read of 0x2A.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h2A, 8'h5C);
        step(1'b1, 1'b1, 1'b0, 8'h2A, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check_val("pread_rm",   32'(bus.mem_rm),   32'd1);
        check_val("pread_addr", 32'(bus.mem_addr), 32'h2A);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check_val("pread_rvalid", 32'(bus.p_rvalid), 32'd1);
        check_val("pread_rdata",  32'(bus.p_rdata),  32'h5C);

        // Loader write 0xA5 to 0x10 then pipeline read.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
        check_val("lwrite_wm", 32'(bus.mem_wm), 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check_val("lwrite_state_load", 32'(bus.burst_active), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check_val("lwrite_rdata", 32'(bus.p_rdata), 32'hA5);
        check_val("lwrite_state_pipe", 32'(bus.burst_active), 32'd0);

        // Burst abort: three loader grants, then loader drops while pipeline requests.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'(8'h40 + i), 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h50, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
        check_val("abort_pgrant", 32'(bus.mem_wm), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check_val("abort_state", 32'(bus.burst_active), 32'd0);

        // Random traffic; requesters hold their inputs until granted.
        c_pr = 1'b0; c_lr = 1'b0; c_pw = 1'b0; c_lw = 1'b0;
        c_pa = 8'h00; c_pd = 8'h00; c_la = 8'h00; c_ld = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if (!(c_pr && !last_pg)) begin
                c_pr = ($urandom_range(0, 3) != 0);
                c_pw = 1'($urandom_range(0, 1));
                c_pa = 8'($urandom_range(0, 15));
                c_pd = 8'($urandom);
            end
            if (!(c_lr && !last_lg)) begin
                c_lr = ($urandom_range(0, 2) != 0);
                c_lw = 1'($urandom_range(0, 1));
                c_la = 8'($urandom_range(0, 15));
                c_ld = 8'($urandom);
            end
            c_rst = ($urandom_range(0, 199) != 0);
            step(c_rst, c_pr, c_pw, c_pa, c_pd, c_lr, c_lw, c_la, c_ld);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
